// File: rtl/gate_response_checker_if.sv
// ---------------------------------------------------------------------------
// gate_response_checker_if
//   Bundles the stimulus/response and result signals of the gate response
//   checker. The master is whatever applies vectors and reads results, and
//   the slave is the checker.
//
//   Stimulus (master -> slave):
//     start     one-cycle pulse that begins a new check run
//     gate_sel  0=AND 1=OR 2=NAND 3=NOR 4=XOR 5=XNOR, 6/7 reserved
//     in_valid  a, b and y are valid this cycle
//     a, b      gate inputs as applied
//     y         gate output observed for {a,b}
//   Results (slave -> master):
//     busy, done, pass, err_cnt, vec_cnt, cov_mask,
//     first_fail, first_fail_vld, timeout
// ---------------------------------------------------------------------------
interface gate_response_checker_if #(
    parameter int unsigned CNT_W = 8
);
    logic             start;
    logic [2:0]       gate_sel;
    logic             in_valid;
    logic             a;
    logic             b;
    logic             y;

    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] vec_cnt;
    logic [3:0]       cov_mask;
    logic [1:0]       first_fail;
    logic             first_fail_vld;
    logic             timeout;

    modport master (
        output start, gate_sel, in_valid, a, b, y,
        input  busy, done, pass, err_cnt, vec_cnt, cov_mask,
               first_fail, first_fail_vld, timeout
    );

    modport slave (
        input  start, gate_sel, in_valid, a, b, y,
        output busy, done, pass, err_cnt, vec_cnt, cov_mask,
               first_fail, first_fail_vld, timeout
    );
endinterface

// File: rtl/gate_response_checker.sv
// ---------------------------------------------------------------------------
// gate_response_checker
//   Receiving end of a two-input gate stimulus sequence. Each accepted vector
//   {a,b} is checked against the truth table of the gate latched at start.
//   Mismatches, accepted vectors and input-combination coverage are tracked;
//   once all four combinations have been seen the run ends with a registered
//   pass/fail verdict.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     bus    gate_response_checker_if.slave (stimulus in, results out)
//
//   Optional feature macro: GATE_CHECK_TIMEOUT_EN
//     Ends a run with timeout=1 / pass=0 after TIMEOUT_CYC consecutive CHECK
//     cycles without a vector. When undefined, timeout is tied to 0.
// ---------------------------------------------------------------------------
module gate_response_checker #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    gate_response_checker_if.slave        bus
);

    if (TIMEOUT_CYC == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be nonzero");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [2:0]       sel_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [CNT_W-1:0] err_q;
    logic [CNT_W-1:0] vec_q;
    logic [3:0]       cov_q;
    logic [1:0]       ff_q;
    logic             ff_vld_q;

    logic             exp_y;
    logic             mismatch;
    logic [1:0]       ab;
    logic [CNT_W-1:0] err_nxt;
    logic [CNT_W-1:0] vec_nxt;
    logic [3:0]       cov_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Next values for an accepted vector; the FSM decides whether to commit.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        exp_y = 1'b0;
        case (sel_q)
            3'd0:    exp_y = bus.a & bus.b;
            3'd1:    exp_y = bus.a | bus.b;
            3'd2:    exp_y = ~(bus.a & bus.b);
            3'd3:    exp_y = ~(bus.a | bus.b);
            3'd4:    exp_y = bus.a ^ bus.b;
            3'd5:    exp_y = ~(bus.a ^ bus.b);
            default: exp_y = 1'b0;      // reserved selects expect 0
        endcase
        ab       = {bus.a, bus.b};
        mismatch = (bus.y != exp_y);
        vec_nxt  = sat_inc(vec_q);
        err_nxt  = mismatch ? sat_inc(err_q) : err_q;
        cov_nxt  = cov_q | (4'b0001 << ab);
    end

`ifdef GATE_CHECK_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYC + 1);
    logic [IDLE_W-1:0] idle_q;
    logic              timeout_q;
`endif

    // NOTE: all state below is sequential and uses non-blocking assignments,
    // so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            vec_q    <= '0;
            cov_q    <= '0;
            ff_q     <= '0;
            ff_vld_q <= 1'b0;
`ifdef GATE_CHECK_TIMEOUT_EN
            idle_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else if (bus.start) begin
            // Start from any state (including mid-run) clears and re-arms;
            // a vector presented on this edge is discarded.
            state    <= CHECK;
            sel_q    <= bus.gate_sel;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            vec_q    <= '0;
            cov_q    <= '0;
            ff_q     <= '0;
            ff_vld_q <= 1'b0;
`ifdef GATE_CHECK_TIMEOUT_EN
            idle_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else if (state == CHECK) begin
            if (bus.in_valid) begin
                vec_q <= vec_nxt;
                err_q <= err_nxt;
                cov_q <= cov_nxt;
                if (mismatch && !ff_vld_q) begin
                    ff_q     <= ab;
                    ff_vld_q <= 1'b1;
                end
`ifdef GATE_CHECK_TIMEOUT_EN
                idle_q <= '0;
`endif
                // Verdict uses the updated error count so the completing
                // vector itself is included.
                if (cov_nxt == 4'b1111) begin
                    state  <= DONE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    pass_q <= (err_nxt == '0) && (sel_q <= 3'd5);
                end
            end
`ifdef GATE_CHECK_TIMEOUT_EN
            else if (idle_q == IDLE_W'(TIMEOUT_CYC - 1)) begin
                state     <= DONE;
                busy_q    <= 1'b0;
                done_q    <= 1'b1;
                pass_q    <= 1'b0;
                timeout_q <= 1'b1;
            end else begin
                idle_q <= idle_q + 1'b1;
            end
`endif
        end
    end

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.err_cnt        = err_q;
    assign bus.vec_cnt        = vec_q;
    assign bus.cov_mask       = cov_q;
    assign bus.first_fail     = ff_q;
    assign bus.first_fail_vld = ff_vld_q;
`ifdef GATE_CHECK_TIMEOUT_EN
    assign bus.timeout        = timeout_q;
`else
    assign bus.timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_gate_response_checker.sv
// ---------------------------------------------------------------------------
// tb_gate_response_checker
//   Directed bench for gate_response_checker. Each clocked step pushes the
//   expected post-edge outputs, computed from a bench-side truth table, onto
//   a scoreboard queue; after the edge the entry is popped and compared.
// ---------------------------------------------------------------------------
module tb_gate_response_checker;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned TO    = 16;

    typedef struct packed {
        logic             busy;
        logic             done;
        logic             pass;
        logic [CNT_W-1:0] err;
        logic [CNT_W-1:0] vec;
        logic [3:0]       cov;
        logic [1:0]       ff;
        logic             ffv;
        logic             to;
    } snap_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    gate_response_checker_if #(.CNT_W(CNT_W)) bus ();

    gate_response_checker #(.CNT_W(CNT_W), .TIMEOUT_CYC(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Truth tables indexed by {a,b}: bit0=00, bit1=01, bit2=10, bit3=11.
    logic [3:0] tt [8] = '{4'b1000, 4'b1110, 4'b0111, 4'b0001,
                           4'b0110, 4'b1001, 4'b0000, 4'b0000};

    int    tests_run    = 0;
    int    tests_failed = 0;
    snap_t sb [$];

    // Reference model state
    snap_t      m;
    logic [2:0] m_sel;
    int         m_idle;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare(input string tag, input snap_t e);
        check({tag, ".busy"},  32'(bus.busy),           32'(e.busy));
        check({tag, ".done"},  32'(bus.done),           32'(e.done));
        check({tag, ".pass"},  32'(bus.pass),           32'(e.pass));
        check({tag, ".err"},   32'(bus.err_cnt),        32'(e.err));
        check({tag, ".vec"},   32'(bus.vec_cnt),        32'(e.vec));
        check({tag, ".cov"},   32'(bus.cov_mask),       32'(e.cov));
        check({tag, ".ff"},    32'(bus.first_fail),     32'(e.ff));
        check({tag, ".ffv"},   32'(bus.first_fail_vld), 32'(e.ffv));
        check({tag, ".to"},    32'(bus.timeout),        32'(e.to));
    endtask

    function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // One clock: drive inputs, advance model, push expectation, pop/compare.
    task automatic step(input string tag, input logic rst, input logic st,
                        input logic [2:0] sel, input logic v,
                        input logic a, input logic b, input logic y);
        logic e;
        snap_t got;
        rst_n        = ~rst;
        bus.start    = st;
        bus.gate_sel = sel;
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        bus.y        = y;
        if (rst) begin
            m = '0; m_sel = '0; m_idle = 0;
        end else if (st) begin
            m = '0; m.busy = 1'b1; m_sel = sel; m_idle = 0;
        end else if (m.busy) begin
            if (v) begin
                e = tt[m_sel][{a, b}];
                m.vec = sat(m.vec);
                m.cov = m.cov | (4'b0001 << {a, b});
                if (y != e) begin
                    m.err = sat(m.err);
                    if (!m.ffv) begin m.ff = {a, b}; m.ffv = 1'b1; end
                end
                m_idle = 0;
                if (m.cov == 4'hF) begin
                    m.busy = 1'b0; m.done = 1'b1;
                    m.pass = (m.err == 0) && (m_sel <= 3'd5);
                end
            end else begin
`ifdef GATE_CHECK_TIMEOUT_EN
                m_idle++;
                if (m_idle == TO) begin
                    m.busy = 1'b0; m.done = 1'b1; m.pass = 1'b0; m.to = 1'b1;
                end
`endif
            end
        end
        sb.push_back(m);
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        got = sb.pop_front();
        compare(tag, got);
    endtask

    task automatic do_reset(input string tag);
        step(tag, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_start(input string tag, input logic [2:0] sel);
        step(tag, 1'b0, 1'b1, sel, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic vec(input string tag, input logic a, input logic b,
                       input logic y);
        step(tag, 1'b0, 1'b0, bus.gate_sel, 1'b1, a, b, y);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++)
            step(tag, 1'b0, 1'b0, bus.gate_sel, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0; bus.gate_sel = 3'd0; bus.in_valid = 1'b0;
        bus.a = 1'b0; bus.b = 1'b0; bus.y = 1'b0;
        m = '0; m_sel = '0; m_idle = 0;

        // Reset state
        do_reset("rst0");
        do_reset("rst1");
        check("rst_done", 32'(bus.done), 32'd0);

        // In IDLE, vectors are ignored
        vec("idle_vec", 1'b1, 1'b1, 1'b0);

        // OR sweep
        do_start("or_start", 3'd1);
        vec("or_00", 1'b0, 1'b0, 1'b0);
        vec("or_01", 1'b0, 1'b1, 1'b1);
        vec("or_10", 1'b1, 1'b0, 1'b1);
        vec("or_11", 1'b1, 1'b1, 1'b1);
        check("or_done", 32'(bus.done),     32'd1);
        check("or_pass", 32'(bus.pass),     32'd1);
        check("or_vec",  32'(bus.vec_cnt),  32'd4);
        check("or_cov",  32'(bus.cov_mask), 32'hF);

        // AND with one injected fault; results then hold through DONE
        do_start("and_start", 3'd0);
        vec("and_00", 1'b0, 1'b0, 1'b0);
        vec("and_01", 1'b0, 1'b1, 1'b1);
        vec("and_10", 1'b1, 1'b0, 1'b0);
        vec("and_11", 1'b1, 1'b1, 1'b1);
        check("and_pass", 32'(bus.pass),       32'd0);
        check("and_err",  32'(bus.err_cnt),    32'd1);
        check("and_ff",   32'(bus.first_fail), 32'd1);
        vec("and_hold", 1'b0, 1'b0, 1'b1);
        idle("and_hold_idle", 2);

        // XOR partial and repeated coverage
        do_start("xor_start", 3'd4);
        vec("xor_00a", 1'b0, 1'b0, 1'b0);
        vec("xor_00b", 1'b0, 1'b0, 1'b0);
        vec("xor_01",  1'b0, 1'b1, 1'b1);
        vec("xor_10",  1'b1, 1'b0, 1'b1);
        check("xor_busy", 32'(bus.busy),     32'd1);
        check("xor_cov",  32'(bus.cov_mask), 32'h7);
        vec("xor_11",  1'b1, 1'b1, 1'b0);
        check("xor_vec5", 32'(bus.vec_cnt),  32'd5);
        check("xor_pass", 32'(bus.pass),     32'd1);

        // Mid-run restart to NOR with a vector on the start edge (discarded),
        // then gate_sel wiggles with no effect on the latched select.
        do_start("rs_start", 3'd4);
        vec("rs_bad", 1'b0, 1'b0, 1'b1);
        step("rs_restart", 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1);
        check("rs_err0", 32'(bus.err_cnt), 32'd0);
        bus.gate_sel = 3'd0;
        vec("nor_00", 1'b0, 1'b0, 1'b1);
        vec("nor_01", 1'b0, 1'b1, 1'b0);
        vec("nor_10", 1'b1, 1'b0, 1'b0);
        vec("nor_11", 1'b1, 1'b1, 1'b0);
        check("nor_pass", 32'(bus.pass), 32'd1);

        // Reset mid-run
        do_start("mr_start", 3'd2);
        vec("mr_00", 1'b0, 1'b0, 1'b0);
        do_reset("mr_rst");
        check("mr_vec0", 32'(bus.vec_cnt), 32'd0);
        vec("mr_ign", 1'b1, 1'b0, 1'b0);

        // Reserved selects: 7 with y=0 everywhere, 6 with one y=1
        do_start("r7_start", 3'd7);
        vec("r7_00", 1'b0, 1'b0, 1'b0);
        vec("r7_01", 1'b0, 1'b1, 1'b0);
        vec("r7_10", 1'b1, 1'b0, 1'b0);
        vec("r7_11", 1'b1, 1'b1, 1'b0);
        check("r7_done", 32'(bus.done),    32'd1);
        check("r7_pass", 32'(bus.pass),    32'd0);
        check("r7_err",  32'(bus.err_cnt), 32'd0);
        do_start("r6_start", 3'd6);
        vec("r6_00", 1'b0, 1'b0, 1'b0);
        vec("r6_01", 1'b0, 1'b1, 1'b0);
        vec("r6_10", 1'b1, 1'b0, 1'b1);
        vec("r6_11", 1'b1, 1'b1, 1'b0);
        check("r6_err", 32'(bus.err_cnt), 32'd1);

        // Saturation: 260 wrong XOR vectors on 00, then complete coverage
        do_start("sat_start", 3'd4);
        for (int i = 0; i < 260; i++) vec("sat_00", 1'b0, 1'b0, 1'b1);
        check("sat_err", 32'(bus.err_cnt), 32'hFF);
        check("sat_vec", 32'(bus.vec_cnt), 32'hFF);
        vec("sat_01", 1'b0, 1'b1, 1'b1);
        vec("sat_10", 1'b1, 1'b0, 1'b1);
        vec("sat_11", 1'b1, 1'b1, 1'b0);
        check("sat_pass", 32'(bus.pass), 32'd0);

        // Idle gap after partial coverage
        do_start("to_start", 3'd4);
        vec("to_00", 1'b0, 1'b0, 1'b0);
        vec("to_01", 1'b0, 1'b1, 1'b1);
        idle("to_idle", int'(TO));
`ifdef GATE_CHECK_TIMEOUT_EN
        check("to_done", 32'(bus.done),     32'd1);
        check("to_flag", 32'(bus.timeout),  32'd1);
        check("to_pass", 32'(bus.pass),     32'd0);
        check("to_cov",  32'(bus.cov_mask), 32'h3);
        do_start("to_clr", 3'd1);
        check("to_clr_flag", 32'(bus.timeout), 32'd0);
`else
        check("to_busy", 32'(bus.busy),    32'd1);
        check("to_flag", 32'(bus.timeout), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/gate_response_checker.md
Name: gate_response_checker

Overview:
- Synthesizable response checker for the basic two-input gate blocks. It is the receiving end of a gate stimulus sequence.
- Samples each applied vector {a,b} together with the DUT output y and compares y against the selected gate's truth table.
- Counts mismatches, tracks coverage of all four input combinations and reports pass/fail once coverage is complete.
- Lets the gate blocks be self-checked on hardware as well as in simulation.

Parameters:
- CNT_W, 8, width of the error and vector counters (saturating).
- TIMEOUT_CYC, 1000, idle cycles allowed between vectors; used only with the optional feature.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a new check run.
- gate_sel  input  3  0=AND 1=OR 2=NAND 3=NOR 4=XOR 5=XNOR; 6,7 reserved.
- in_valid  input  1  a, b and y are valid this cycle.
- a  input  1  DUT input a as applied.
- b  input  1  DUT input b as applied.
- y  input  1  DUT output for {a,b}.
- busy  output  1  high in CHECK.
- done  output  1  high in DONE.
- pass  output  1  valid when done: 1 = zero errors and legal gate_sel.
- err_cnt  output  CNT_W  mismatch count, saturates at all-ones.
- vec_cnt  output  CNT_W  accepted vector count, saturates.
- cov_mask  output  4  bit {a,b} is set once that combination has been seen.
- first_fail  output  2  {a,b} of the first mismatch.
- first_fail_vld  output  1  first_fail holds a captured value.
- timeout  output  1  run ended by timeout; tied 0 when the feature is disabled.

Behaviour:
- Reset (rst_n=0 at a clk edge) overrides all other inputs, including mid-run:
  - state=IDLE.
  - busy, done, pass, err_cnt, vec_cnt, cov_mask, first_fail, first_fail_vld and timeout all 0.
- States:
  - IDLE: start=1 -> CHECK. On the same edge, latch gate_sel into sel_q and clear the counters, cov_mask, first_fail and first_fail_vld.
  - CHECK: each edge with in_valid=1 does all of the following:
    - exp = f(sel_q, a, b).
    - vec_cnt increments.
    - cov_mask[{a,b}] is set.
    - If y != exp: err_cnt increments. If first_fail_vld=0, capture first_fail={a,b} and set first_fail_vld=1.
  - CHECK -> DONE: on the edge where the updated cov_mask becomes 4'b1111.
    - pass is registered on that same edge: pass = (updated err_cnt==0) and (sel_q<=5).
    - done and pass are therefore visible one cycle after the completing vector is presented. Latency is 1 clock.
  - DONE: all results hold. start=1 -> CHECK, with the same clearing as from IDLE. in_valid is ignored.
- in_valid is ignored in IDLE and DONE.
- start=1 in CHECK restarts the run: clear, re-latch gate_sel, stay in CHECK. Any in_valid on that edge is discarded.
- Repeated combinations are all checked and counted; coverage completes on the first time all four have been seen.
- Reserved sel_q (6,7):
  - exp=0 for every vector.
  - pass is forced to 0 at DONE.
  - err_cnt still counts mismatches against exp=0.
- Counter saturation: err_cnt and vec_cnt hold at 2^CNT_W-1 and never wrap. A saturated err_cnt still gives pass=0.
- gate_sel changes after start have no effect until the next start.

Optional Feature:
- Macro: GATE_CHECK_TIMEOUT_EN.
- When defined:
  - An idle counter clears on start and on every accepted vector, and increments each CHECK cycle with in_valid=0.
  - On reaching TIMEOUT_CYC: go to DONE with pass=0, timeout=1. Counters and cov_mask hold their partial values.
  - timeout clears on reset or start.
- When undefined: no counter logic; timeout tied 0; CHECK waits indefinitely for coverage.

Test Plan:
- OR sweep: start, gate_sel=1; present 00->0, 01->1, 10->1, 11->1, one per cycle -> done=1 and pass=1 the cycle after 11; err_cnt=0, vec_cnt=4, cov_mask=4'hF.
- Fault injection: gate_sel=0 (AND); present 00->0, 01->1 (wrong), 10->0, 11->1 -> pass=0, err_cnt=1, first_fail=2'b01, first_fail_vld=1.
- Partial and repeated coverage: gate_sel=4 (XOR); send 00,00,01,10 -> busy stays 1, cov_mask=4'h7, vec_cnt=4; then send 11 -> done, vec_cnt=5.
- Restart and reset: mid-run start with gate_sel=3 -> counters=0 and NOR is checked. rst_n=0 for one edge mid-run -> IDLE with all outputs 0.
- Reserved select: gate_sel=7; all y=0 for the four vectors -> done=1, pass=0, err_cnt=0.
- Timeout (with GATE_CHECK_TIMEOUT_EN, TIMEOUT_CYC=16): send 00 and 01, then idle 16 cycles -> done=1, timeout=1, pass=0, cov_mask=4'h3. Without the macro, the same stimulus leaves busy=1 and timeout=0.
